// File: rtl/cpu_pkg.sv
// Shared types and constants for the interrupt sequencer.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      S4   = 3'd4,
      S5   = 3'd5,
      S6   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      SOFT_BRK = 2'd0,
      HW_IRQ   = 2'd1,
      HW_NMI   = 2'd2,
      HW_RES   = 2'd3
   } seq_t;

   localparam logic [7:0] NMI_VEC_LO_DEF = 8'hFA;
   localparam logic [7:0] RES_VEC_LO_DEF = 8'hFC;
   localparam logic [7:0] IRQ_VEC_LO_DEF = 8'hFE;

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-flop synchroniser for an active-low asynchronous pin.
// The flops reset to 1, which is the idle level of the pin.
module pin_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic sync
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '1;
      else     ff <= {ff[STAGES-2:0], pin};
   end

   assign sync = ff[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// BRK/IRQ/NMI/RESET sequencer for the 7-cycle interrupt entry.
// Pin sync, NMI edge latch, IRQ masking and vector selection.
module interrupt_sequencer
   import cpu_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] NMI_VEC_LO  = NMI_VEC_LO_DEF,
   parameter logic [7:0] RES_VEC_LO  = RES_VEC_LO_DEF,
   parameter logic [7:0] IRQ_VEC_LO  = IRQ_VEC_LO_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       rdy,
   input  logic       sync_fetch,
   input  logic       brk_opcode,
   input  logic       interrupt_flag,
   output logic       seq_active,
   output logic [2:0] seq_cycle,
   output logic       inject_brk,
   output logic       write_inhibit,
   output logic       b_out_n,
   output logic       break_done,
   output logic [7:0] vec_lo
);

   state_t state;
   seq_t   kind;
   seq_t   vec_kind;
   logic   irq_s;
   logic   nmi_s;
   logic   nmi_prev;
   logic   nmi_latch;
   logic   res_latch;
   logic   nmi_edge;
   logic   irq_req;
   logic   fire6;

   pin_synchronizer #(.STAGES(SYNC_STAGES)) u_irq_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (irq_n),
      .sync (irq_s)
   );

   pin_synchronizer #(.STAGES(SYNC_STAGES)) u_nmi_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (nmi_n),
      .sync (nmi_s)
   );

   assign nmi_edge   = nmi_prev & ~nmi_s;
   assign irq_req    = ~irq_s & ~interrupt_flag;
   assign fire6      = rdy && (state == S6);
   assign break_done = fire6;
   assign seq_active = (state != IDLE);
   assign seq_cycle  = state;

   // Edge detect runs every cycle; a new edge beats the S6 clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi_prev  <= 1'b1;
         nmi_latch <= 1'b0;
      end else begin
         nmi_prev <= nmi_s;
         if (nmi_edge)
            nmi_latch <= 1'b1;
         else if (fire6 && vec_kind == HW_NMI)
            nmi_latch <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         kind          <= SOFT_BRK;
         vec_kind      <= HW_IRQ;
         res_latch     <= 1'b1;
         inject_brk    <= 1'b0;
         write_inhibit <= 1'b0;
         b_out_n       <= 1'b1;
         vec_lo        <= IRQ_VEC_LO;
      end else if (rdy) begin
         unique case (state)
            IDLE: begin
               if (res_latch) begin
                  state   <= S1;
                  kind    <= HW_RES;
                  b_out_n <= 1'b0;
               end else if (sync_fetch && (nmi_latch || irq_req)) begin
                  state      <= S1;
                  kind       <= HW_IRQ;
                  b_out_n    <= 1'b0;
                  inject_brk <= 1'b1;
               end else if (sync_fetch && brk_opcode) begin
                  state   <= S1;
                  kind    <= SOFT_BRK;
                  b_out_n <= 1'b1;
               end
            end
            S1: begin
               state         <= S2;
               inject_brk    <= 1'b0;
               write_inhibit <= (kind == HW_RES);
            end
            S2: state <= S3;
            S3: state <= S4;
            // An NMI seen up to this edge hijacks the vector.
            S4: begin
               state         <= S5;
               write_inhibit <= 1'b0;
               if (res_latch) begin
                  vec_kind <= HW_RES;
                  vec_lo   <= RES_VEC_LO;
               end else if (nmi_latch || nmi_edge) begin
                  vec_kind <= HW_NMI;
                  vec_lo   <= NMI_VEC_LO;
               end else begin
                  vec_kind <= HW_IRQ;
                  vec_lo   <= IRQ_VEC_LO;
               end
            end
            S5: begin
               state  <= S6;
               vec_lo <= vec_lo | 8'h01;
            end
            S6: begin
               state   <= IDLE;
               b_out_n <= 1'b1;
               if (vec_kind == HW_RES) res_latch <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
module tb_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       irq_n;
   logic       nmi_n;
   logic       rdy;
   logic       sync_fetch;
   logic       brk_opcode;
   logic       interrupt_flag;
   logic       seq_active;
   logic [2:0] seq_cycle;
   logic       inject_brk;
   logic       write_inhibit;
   logic       b_out_n;
   logic       break_done;
   logic [7:0] vec_lo;

   int vecs = 0;
   int errs = 0;

   interrupt_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .irq_n          (irq_n),
      .nmi_n          (nmi_n),
      .rdy            (rdy),
      .sync_fetch     (sync_fetch),
      .brk_opcode     (brk_opcode),
      .interrupt_flag (interrupt_flag),
      .seq_active     (seq_active),
      .seq_cycle      (seq_cycle),
      .inject_brk     (inject_brk),
      .write_inhibit  (write_inhibit),
      .b_out_n        (b_out_n),
      .break_done     (break_done),
      .vec_lo         (vec_lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks cycle number, B bit, write inhibit and break pulse together.
   task automatic step(input string tag, input logic [2:0] cyc,
                       input logic bn, input logic wi, input logic bd);
      chk({tag, "_cyc"}, {5'd0, seq_cycle}, {5'd0, cyc});
      chk({tag, "_bn"},  {7'd0, b_out_n}, {7'd0, bn});
      chk({tag, "_wi"},  {7'd0, write_inhibit}, {7'd0, wi});
      chk({tag, "_bd"},  {7'd0, break_done}, {7'd0, bd});
   endtask

   initial begin
      rst = 1'b1; irq_n = 1'b1; nmi_n = 1'b1; rdy = 1'b1;
      sync_fetch = 1'b0; brk_opcode = 1'b0; interrupt_flag = 1'b1;
      tick(); tick();
      chk("rst_active", {7'd0, seq_active}, 8'd0);
      step("rst", 3'd0, 1'b1, 1'b0, 1'b0);
      chk("rst_inj", {7'd0, inject_brk}, 8'd0);
      chk("rst_vec", vec_lo, 8'hFE);

      // Reset sequence after release
      rst = 1'b0;
      tick(); step("res1", 3'd1, 1'b0, 1'b0, 1'b0);
      chk("res1_inj", {7'd0, inject_brk}, 8'd0);
      tick(); step("res2", 3'd2, 1'b0, 1'b1, 1'b0);
      tick(); step("res3", 3'd3, 1'b0, 1'b1, 1'b0);
      tick(); step("res4", 3'd4, 1'b0, 1'b1, 1'b0);
      tick(); step("res5", 3'd5, 1'b0, 1'b0, 1'b0);
      chk("res5_vec", vec_lo, 8'hFC);
      tick(); step("res6", 3'd6, 1'b0, 1'b0, 1'b1);
      chk("res6_vec", vec_lo, 8'hFD);
      tick(); step("res_idle", 3'd0, 1'b1, 1'b0, 1'b0);
      chk("res_idle_vec", vec_lo, 8'hFD);
      tick(); chk("res_norestart", {7'd0, seq_active}, 8'd0);

      // IRQ, unmasked; pin released right after start
      interrupt_flag = 1'b0; irq_n = 1'b0;
      tick(); tick(); tick();
      chk("irq_nofetch", {7'd0, seq_active}, 8'd0);
      sync_fetch = 1'b1;
      tick(); step("irq1", 3'd1, 1'b0, 1'b0, 1'b0);
      chk("irq1_inj", {7'd0, inject_brk}, 8'd1);
      sync_fetch = 1'b0; irq_n = 1'b1;
      tick(); step("irq2", 3'd2, 1'b0, 1'b0, 1'b0);
      chk("irq2_inj", {7'd0, inject_brk}, 8'd0);
      tick(); step("irq3", 3'd3, 1'b0, 1'b0, 1'b0);
      tick(); step("irq4", 3'd4, 1'b0, 1'b0, 1'b0);
      tick(); chk("irq5_vec", vec_lo, 8'hFE);
      tick(); step("irq6", 3'd6, 1'b0, 1'b0, 1'b1);
      chk("irq6_vec", vec_lo, 8'hFF);
      tick(); step("irq_idle", 3'd0, 1'b1, 1'b0, 1'b0);

      // IRQ masked by I flag
      interrupt_flag = 1'b1; irq_n = 1'b0;
      tick(); tick(); tick();
      sync_fetch = 1'b1;
      tick(); chk("irq_masked", {7'd0, seq_active}, 8'd0);
      sync_fetch = 1'b0; irq_n = 1'b1;
      tick(); tick(); tick();

      // BRK hijacked by NMI arriving during S3
      sync_fetch = 1'b1; brk_opcode = 1'b1;
      tick(); step("brk1", 3'd1, 1'b1, 1'b0, 1'b0);
      chk("brk1_inj", {7'd0, inject_brk}, 8'd0);
      sync_fetch = 1'b0; brk_opcode = 1'b0; nmi_n = 1'b0;
      tick(); step("brk2", 3'd2, 1'b1, 1'b0, 1'b0);
      tick(); step("brk3", 3'd3, 1'b1, 1'b0, 1'b0);
      tick(); tick(); chk("hij5_vec", vec_lo, 8'hFA);
      tick(); step("hij6", 3'd6, 1'b1, 1'b0, 1'b1);
      chk("hij6_vec", vec_lo, 8'hFB);
      tick(); chk("hij_idle", {7'd0, seq_active}, 8'd0);
      sync_fetch = 1'b1;
      tick(); chk("nmi_cleared", {7'd0, seq_active}, 8'd0);
      sync_fetch = 1'b0; nmi_n = 1'b1;
      tick(); tick(); tick();

      // rdy low at S4
      sync_fetch = 1'b1; brk_opcode = 1'b1;
      tick();
      sync_fetch = 1'b0; brk_opcode = 1'b0;
      tick(); tick(); tick();
      chk("rdy_s4", {5'd0, seq_cycle}, 8'd4);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); step("rdy_hold", 3'd4, 1'b1, 1'b0, 1'b0);
      end
      rdy = 1'b1;
      tick(); chk("rdy_s5", {5'd0, seq_cycle}, 8'd5);
      chk("rdy_s5_vec", vec_lo, 8'hFE);
      tick(); chk("rdy_s6_bd", {7'd0, break_done}, 8'd1);
      rdy = 1'b0; #1;
      chk("rdy_s6_stall_bd", {7'd0, break_done}, 8'd0);
      tick(); chk("rdy_s6_hold", {5'd0, seq_cycle}, 8'd6);
      rdy = 1'b1; #1;
      chk("rdy_s6_resume_bd", {7'd0, break_done}, 8'd1);
      tick(); chk("rdy_idle", {7'd0, seq_active}, 8'd0);

      // NMI edge during S5 is taken at the next boundary
      sync_fetch = 1'b1; brk_opcode = 1'b1;
      tick();
      sync_fetch = 1'b0; brk_opcode = 1'b0;
      tick(); tick(); tick();
      nmi_n = 1'b0;
      tick(); chk("late_s5_vec", vec_lo, 8'hFE);
      tick(); chk("late_s6_vec", vec_lo, 8'hFF);
      tick(); chk("late_idle", {7'd0, seq_active}, 8'd0);
      sync_fetch = 1'b1;
      tick(); step("nmi1", 3'd1, 1'b0, 1'b0, 1'b0);
      chk("nmi1_inj", {7'd0, inject_brk}, 8'd1);
      sync_fetch = 1'b0; nmi_n = 1'b1;
      tick(); tick(); tick(); tick();
      chk("nmi5_vec", vec_lo, 8'hFA);
      tick(); tick();
      chk("nmi_idle", {7'd0, seq_active}, 8'd0);

      // Async reset in S3
      sync_fetch = 1'b1; brk_opcode = 1'b1;
      tick();
      sync_fetch = 1'b0; brk_opcode = 1'b0;
      tick(); tick();
      chk("pre_rst_s3", {5'd0, seq_cycle}, 8'd3);
      rst = 1'b1; #1;
      step("mid_rst", 3'd0, 1'b1, 1'b0, 1'b0);
      chk("mid_rst_vec", vec_lo, 8'hFE);
      tick();
      rst = 1'b0;
      tick(); step("rr1", 3'd1, 1'b0, 1'b0, 1'b0);
      tick(); step("rr2", 3'd2, 1'b0, 1'b1, 1'b0);
      tick(); tick(); tick();
      chk("rr5_vec", vec_lo, 8'hFC);
      tick(); step("rr6", 3'd6, 1'b0, 1'b0, 1'b1);
      chk("rr6_vec", vec_lo, 8'hFD);
      tick(); chk("rr_idle", {7'd0, seq_active}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sits beside processor_status_register and ahead of the instruction register.
- Synchronises the external irq_n/nmi_n pins, detects NMI edges and masks IRQ with interrupt_flag.
- At instruction boundaries it launches the 7-cycle BRK/IRQ/NMI/RESET sequence and selects the vector.
- It produces the break_done and b_out_n signals that processor_status_register consumes.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchroniser (min 2).
- NMI_VEC_LO, 8'hFA, low byte of NMI vector address (page FF).
- RES_VEC_LO, 8'hFC, low byte of RESET vector address.
- IRQ_VEC_LO, 8'hFE, low byte of IRQ/BRK vector address.

Ports:
- clk, in, 1, sole clock; all state on rising edge.
- rst, in, 1, asynchronous active-high reset.
- irq_n, in, 1, IRQ pin; asynchronous, level, active low.
- nmi_n, in, 1, NMI pin; asynchronous, falling-edge active.
- rdy, in, 1, cycle advance enable; 0 freezes all sequencing state (synchronisers still run).
- sync_fetch, in, 1, current cycle is an opcode fetch (instruction boundary).
- brk_opcode, in, 1, the fetched opcode is BRK (0x00).
- interrupt_flag, in, 1, I flag from processor_status_register.
- seq_active, out, 1, sequence in progress.
- seq_cycle, out, 3, sequence step 1..6; 0 when idle.
- inject_brk, out, 1, force IR load of 0x00 instead of the fetched opcode.
- write_inhibit, out, 1, convert the stack pushes to reads (reset only).
- b_out_n, out, 1, B bit pushed to stack: 1 = BRK/PHP, 0 = hardware interrupt.
- break_done, out, 1, one-cycle pulse that sets I (net brk_6e equivalent).
- vec_lo, out, 8, low byte of vector address for steps 5/6.

Behaviour:
- Reset (async):
  - seq_active=0, seq_cycle=0, inject_brk=0, write_inhibit=0, b_out_n=1, break_done=0, vec_lo=IRQ_VEC_LO.
  - nmi_latch=0; res_latch=1; synchroniser flops all set to 1 (pins idle).
- Pin sync: irq_s/nmi_s are the SYNC_STAGES-delayed pins.
- NMI latch:
  - nmi_latch is set on a 1->0 transition of nmi_s (the previous nmi_s is stored), regardless of rdy.
  - It is cleared on the step-6 edge when the NMI vector was selected.
  - A new edge on that same edge keeps it set (set wins).
- irq_req = ~irq_s & ~interrupt_flag. Level sensitive, not latched.
- Start condition, evaluated only when rdy=1 and the FSM is idle:
  - If res_latch: start a sequence on the first enabled cycle after reset release, without waiting for sync_fetch. Hardware type, write_inhibit=1.
  - Else if sync_fetch and (nmi_latch or irq_req): start a hardware sequence, inject_brk=1 for that cycle.
  - Else if sync_fetch and brk_opcode: start a software sequence.
- FSM states: IDLE -> S1 -> S2 -> S3 -> S4 -> S5 -> S6 -> IDLE. Each step advances only when rdy=1; seq_cycle shows the step number.
- S1: operand dummy read.
- S2..S4: pushes of PCH, PCL, P.
  - b_out_n=0 throughout a hardware sequence and 1 for software.
  - write_inhibit=1 during S2..S4 only for a reset sequence.
- Vector select is latched on the S4 edge:
  - Priority: res_latch > nmi_latch > otherwise IRQ.
  - NMI hijack: an NMI latched before or during S4 redirects a BRK/IRQ to NMI_VEC_LO.
- vec_lo = selected base in S5 and base|1 in S6. Holds the last value when idle.
- S6 (rdy=1):
  - break_done=1 for exactly that cycle.
  - Clear res_latch if RES was selected, and nmi_latch if NMI was selected.
  - IRQ is not acknowledged internally: the I flag set by break_done masks it.
- Boundary cases:
  - rdy low mid-sequence: all outputs hold and break_done stays 0 until the S6 cycle with rdy=1.
  - rst mid-sequence aborts to IDLE and restarts with a reset sequence.
  - IRQ deasserting after the start still completes the sequence through the IRQ vector.
  - NMI edge in S5/S6 stays latched and is taken at the next boundary.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encoding (IDLE, S1..S6).
  - Vector low-byte constants.
  - Sequence-type enum (SOFT_BRK, HW_IRQ, HW_NMI, HW_RES).
- One sub-module: pin_synchronizer (SYNC_STAGES flops, reset-to-1), instantiated for irq_n and nmi_n.

Test Plan:
- rst pulse, then release with rdy=1 -> seq_cycle 1..6 on successive cycles, write_inhibit=1 in S2..S4, vec_lo=FC then FD, break_done in S6 only, then idle.
- irq_n=0, interrupt_flag=0, sync_fetch=1 -> inject_brk=1, b_out_n=0 in S2..S4, vec_lo FE/FF. Repeat with interrupt_flag=1 -> no start.
- BRK: brk_opcode=1, sync_fetch=1 -> b_out_n=1, vec_lo FE/FF, break_done pulse.
- BRK started, nmi_n falls so that nmi_s drops at S3 -> vec_lo FA/FB (hijack), nmi_latch cleared after S6, no second NMI sequence.
- rdy=0 for 3 cycles at S4 -> seq_cycle holds 4, no break_done, resumes S5 after rdy=1.
- Sequence at S3, async rst asserted -> immediate outputs reset; after release, full reset sequence to FC/FD.
